// File: rtl/decoder38_grant.sv
// ---------------------------------------------------------------------------
// decoder38_grant
// Grant-side counterpart of the 8:3 priority encoder. Accepts an encoded
// request {code, code_valid} when enabled and idle, then holds a registered
// one-hot grant to that requester until done, a hold timeout, or loss of en.
// After a done/timeout release, a programmable idle gap elapses before the
// next code is accepted.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-high reset
//   en          in   block enable
//   code_valid  in   encoded request present
//   code        in   [2:0] encoded requester index
//   code_ready  out  block accepts a code this cycle (combinational)
//   done        in   granted requester finished (pulse or level)
//   grant       out  [7:0] registered one-hot grant
//   grant_valid out  high while any grant bit is set
//   code_q      out  [2:0] code of the current/last grant
//   timeout     out  one-cycle pulse when a grant is released by timeout
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for code_valid while en is high; code_ready follows en
// S_GRANT | grant held; hold timer running; code input ignored
// S_GAP   | post-release idle gap; code_ready low
// ---------------------------------------------------------------------------
module decoder38_grant #(
   parameter int TIMEOUT = 16,
   parameter int GAP     = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       code_valid,
   input  logic [2:0] code,
   output logic       code_ready,
   input  logic       done,
   output logic [7:0] grant,
   output logic       grant_valid,
   output logic [2:0] code_q,
   output logic       timeout
);

   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int GW = ($clog2(GAP + 1) > 0) ? $clog2(GAP + 1) : 1;

   // TIMEOUT=0 leaves T_LAST unused: the timeout branch is gated off.
   localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [TW-1:0] T_MAX  = {TW{1'b1}};
   localparam logic [GW-1:0] G_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t          state;
   logic [TW-1:0]   timer;
   logic [GW-1:0]   gap_cnt;

   assign code_ready = en & (state == S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         grant       <= 8'h00;
         grant_valid <= 1'b0;
         code_q      <= 3'd0;
         timeout     <= 1'b0;
         timer       <= '0;
         gap_cnt     <= '0;
      end else begin
         timeout <= 1'b0;
         case (state)
            S_IDLE: begin
               if (code_valid && code_ready) begin
                  code_q      <= code;
                  grant       <= 8'd1 << code;
                  grant_valid <= 1'b1;
                  timer       <= '0;
                  state       <= S_GRANT;
               end
            end

            S_GRANT: begin
               // Losing en outranks done and timeout and skips the gap.
               if (!en) begin
                  grant       <= 8'h00;
                  grant_valid <= 1'b0;
                  state       <= S_IDLE;
               end else if (done) begin
                  grant       <= 8'h00;
                  grant_valid <= 1'b0;
                  gap_cnt     <= '0;
                  state       <= S_GAP;
               end else if ((TIMEOUT != 0) && (timer == T_LAST)) begin
                  grant       <= 8'h00;
                  grant_valid <= 1'b0;
                  timeout     <= 1'b1;
                  gap_cnt     <= '0;
                  state       <= S_GAP;
               end else if (timer != T_MAX) begin
                  timer <= timer + 1'b1;
               end
            end

            S_GAP: begin
               if (!en || (gap_cnt == G_LAST)) begin
                  state <= S_IDLE;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end

            default: begin
               grant       <= 8'h00;
               grant_valid <= 1'b0;
               state       <= S_IDLE;
            end
         endcase
      end
   end

endmodule
